// File: rtl/data_mem_io_if.sv
// Word-wide memory bus between a processor core and the data memory / I/O block.
// The core drives address, write data and write enable; the block returns read data.
interface data_mem_io_if #(
    parameter int DW = 16,
    parameter int AW = 13
);
    logic [DW-1:0] din;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] dout;

    modport master (output din, output addr, output we, input dout);
    modport slave  (input din, input addr, input we, output dout);
endinterface

// File: rtl/data_mem_io.sv
// Data RAM plus memory-mapped GPIO and interrupt registers, with a one-cycle
// registered-address read path and edge-triggered GPIO interrupts.
module data_mem_io #(
    parameter int DW      = 16,
    parameter int AW      = 13,
    parameter int RAM_AW  = 7,
    parameter int NGPIO   = 2,
    parameter int IO_BASE = 'h100
) (
    input  logic               clk,
    input  logic               rst,
    data_mem_io_if.slave       bus,
    input  logic [NGPIO*DW-1:0] gpio_in,
    output logic [NGPIO*DW-1:0] gpio_out,
    output logic               irq
);
    localparam logic [AW-1:0] IO_BASE_A = AW'(IO_BASE);
    localparam logic [AW-1:0] IO_SPAN_A = AW'(2 * NGPIO + 2);
    localparam logic [AW-2:0] NG_A      = (AW-1)'(NGPIO);

    typedef enum logic [2:0] {K_RAM, K_GPI, K_GPO, K_STAT, K_EN} kind_e;

    function automatic kind_e decode_kind(input logic [AW-1:0] a);
        logic [AW-1:0] off;
        off = a - IO_BASE_A;
        decode_kind = K_RAM;
        if (a >= IO_BASE_A && off < IO_SPAN_A) begin
            if (off[AW-1:1] < NG_A) decode_kind = off[0] ? K_GPO : K_GPI;
            else                    decode_kind = off[0] ? K_EN  : K_STAT;
        end
    endfunction

    function automatic int decode_ch(input logic [AW-1:0] a);
        logic [AW-1:0] off;
        off = a - IO_BASE_A;
        decode_ch = int'(off[AW-1:1]);
    endfunction

    logic [DW-1:0]       mem [2**RAM_AW];
    logic [AW-1:0]       addr_r;
    logic [NGPIO*DW-1:0] s1, s2, s3;
    logic [NGPIO-1:0]    irq_stat, irq_en, stat_set, stat_clr;
    kind_e               wr_kind, rd_kind;
    int                  wr_ch, rd_ch;

    always_comb begin
        wr_kind = decode_kind(bus.addr);
        wr_ch   = decode_ch(bus.addr);
        rd_kind = decode_kind(addr_r);
        rd_ch   = decode_ch(addr_r);
    end

    // A channel flags an event whenever its synchronised value differs from last cycle's.
    always_comb begin
        stat_set = '0;
        for (int k = 0; k < NGPIO; k++)
            stat_set[k] = (s2[k*DW +: DW] != s3[k*DW +: DW]);
        stat_clr = (bus.we && wr_kind == K_STAT) ? bus.din[NGPIO-1:0] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1       <= '0;
            s2       <= '0;
            s3       <= '0;
            irq_stat <= '0;
            irq_en   <= '0;
            irq      <= 1'b0;
            addr_r   <= '0;
            gpio_out <= '0;
        end else begin
            s1       <= gpio_in;
            s2       <= s1;
            s3       <= s2;
            irq_stat <= (irq_stat & ~stat_clr) | stat_set;
            irq      <= |(irq_stat & irq_en);
            if (!bus.we)
                addr_r <= bus.addr;
            if (bus.we && wr_kind == K_EN)
                irq_en <= bus.din[NGPIO-1:0];
            if (bus.we && wr_kind == K_GPO) begin
                for (int k = 0; k < NGPIO; k++)
                    if (wr_ch == k) gpio_out[k*DW +: DW] <= bus.din;
            end
        end
    end

    // RAM has no reset, so a write landing during reset still completes.
    always_ff @(posedge clk) begin
        if (bus.we && wr_kind == K_RAM)
            mem[bus.addr[RAM_AW-1:0]] <= bus.din;
    end

    always_comb begin
        bus.dout = '0;
        case (rd_kind)
            K_RAM:  bus.dout = mem[addr_r[RAM_AW-1:0]];
            K_GPI:  for (int k = 0; k < NGPIO; k++)
                        if (rd_ch == k) bus.dout = s2[k*DW +: DW];
            K_GPO:  for (int k = 0; k < NGPIO; k++)
                        if (rd_ch == k) bus.dout = gpio_out[k*DW +: DW];
            K_STAT: bus.dout = DW'(irq_stat);
            K_EN:   bus.dout = DW'(irq_en);
            default: bus.dout = '0;
        endcase
    end
endmodule
